// File: rtl/pf_req_handler.sv
// pf_req_handler: queues I-cache prefetch misses, issues them to memory and fills the cache on completion.
module pf_req_handler #(
    parameter int QDEPTH = 4,
    parameter bit EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pf_request_valid,
    input  logic [63:0] pf_requested_addr,
    output logic        icache_pf_stall,
    input  logic        pf_flush,
    input  logic        pf_lookup_hit,
    input  logic        demand_mem_busy,
    output logic [1:0]  proc2mem_command,
    output logic [63:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_response,
    input  logic [3:0]  mem2proc_tag,
    input  logic [63:0] mem2proc_data,
    output logic        pf_wr_en,
    output logic [63:0] pf_wr_addr,
    output logic [63:0] pf_wr_data
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;
    localparam int AW = $clog2(QDEPTH);

    logic [60:0]   fifo [QDEPTH];
    logic [60:0]   mshr_addr [16];
    logic [15:0]   mshr_valid;
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [60:0]   blk;
    logic          full, issue, accept, comp, dup, enq, unused_lo;

    assign blk       = pf_requested_addr[63:3];
    assign unused_lo = ^pf_requested_addr[2:0];
    assign full      = count == (AW+1)'(QDEPTH);
    // reset gates the combinational outputs so nothing leaks from pre-reset state
    assign issue     = EN && !reset && count != '0 && !demand_mem_busy;
    assign accept    = issue && mem2proc_response != 4'd0;
    assign comp      = !reset && mem2proc_tag != 4'd0 && mshr_valid[mem2proc_tag];

    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++)
            if ({1'b0, AW'(i) - head} < count && fifo[i] == blk) dup = 1'b1;
        for (int i = 1; i < 16; i++)
            if (mshr_valid[i] && mshr_addr[i] == blk) dup = 1'b1;
    end

    assign enq = EN && pf_request_valid && !pf_lookup_hit && !pf_flush && !full && !dup;

    assign icache_pf_stall  = !reset && full;
    assign proc2mem_command = issue ? BUS_LOAD : BUS_NONE;
    assign proc2mem_addr    = issue ? {fifo[head], 3'b0} : 64'd0;
    assign pf_wr_en         = comp;
    assign pf_wr_addr       = comp ? {mshr_addr[mem2proc_tag], 3'b0} : 64'd0;
    assign pf_wr_data       = comp ? mem2proc_data : 64'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            mshr_valid <= '0;
        end else begin
            // clear before set so a same-tag accept wins over its own completion
            if (comp) mshr_valid[mem2proc_tag] <= 1'b0;
            if (accept) begin
                mshr_valid[mem2proc_response] <= 1'b1;
                mshr_addr[mem2proc_response]  <= fifo[head];
            end
            if (enq) fifo[tail] <= blk;
            head  <= pf_flush ? '0 : head + AW'(accept);
            tail  <= pf_flush ? '0 : tail + AW'(enq);
            count <= pf_flush ? '0 : count + (AW+1)'(enq) - (AW+1)'(accept);
        end
    end
endmodule

// File: doc/pf_req_handler.md
PF_REQ_HANDLER -- requirements
Module: pf_req_handler

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, request FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter EN, default 1; when 0, no request is enqueued and proc2mem_command stays BUS_NONE.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pf_request_valid  input  1  prefetch request from the prefetcher.
REQ-006 SHALL have port pf_requested_addr  input  64  requested PC; bits [2:0] ignored, block address = addr[63:3].
REQ-007 SHALL have port icache_pf_stall  output  1  FIFO full; requests this cycle are dropped.
REQ-008 SHALL have port pf_flush  input  1  branch recovery; discards all queued requests that have not been issued.
REQ-009 SHALL have port pf_lookup_hit  input  1  I-cache tag-array hit for pf_requested_addr this cycle (combinational).
REQ-010 SHALL have port demand_mem_busy  input  1  demand fetch owns the memory bus this cycle.
REQ-011 SHALL have port proc2mem_command  output  2  BUS_NONE or BUS_LOAD.
REQ-012 SHALL have port proc2mem_addr  output  64  block-aligned issue address ({block,3'b0}).
REQ-013 SHALL have port mem2proc_response  input  4  issue tag; 0 = request not accepted.
REQ-014 SHALL have port mem2proc_tag  input  4  completion tag; 0 = no completion.
REQ-015 SHALL have port mem2proc_data  input  64  completion data.
REQ-016 SHALL have ports pf_wr_en / pf_wr_addr / pf_wr_data  output  1/64/64  I-cache fill write.

Function
REQ-017 Enqueue conditions: EN, pf_request_valid, !pf_lookup_hit, !pf_flush, FIFO not full, and block address matching no valid FIFO entry, no valid MSHR, and no completing MSHR this cycle. Otherwise the request SHALL be dropped silently.
REQ-018 The FIFO SHALL be registered: an entry enqueued in cycle N is at the head, and may issue, no earlier than cycle N+1.
REQ-019 icache_pf_stall SHALL equal (count == QDEPTH) from registered state. An enqueue SHALL NOT occur while full, even if the head dequeues in the same cycle.
REQ-020 Issue: when the FIFO is non-empty and !demand_mem_busy, proc2mem_command SHALL be BUS_LOAD with proc2mem_addr = head address (combinational). Otherwise it SHALL be BUS_NONE and proc2mem_addr SHALL be 0.
REQ-021 An issued request with mem2proc_response != 0 SHALL pop the head and set MSHR[response] = {valid, block address} at the next edge. With response == 0, the head SHALL remain and be reissued on the next eligible cycle.
REQ-022 There SHALL be 15 MSHRs, indexed by tags 1..15; tag 0 is never stored.
REQ-023 Completion: when mem2proc_tag != 0 and MSHR[tag] is valid, pf_wr_en = 1, pf_wr_addr = {MSHR addr,3'b0} and pf_wr_data = mem2proc_data in the same cycle (combinational), and the MSHR SHALL be cleared at the edge.
REQ-024 A completion tag with no valid MSHR (a demand response) SHALL be ignored, with pf_wr_en = 0.
REQ-025 Completion and accept of the same tag in one cycle: the write SHALL use the old entry, and the new entry SHALL be set at the edge.
REQ-026 pf_flush SHALL clear the FIFO (count = 0, pointers reset) at the edge. A head accepted by memory in the flush cycle SHALL still enter its MSHR. Outstanding MSHRs SHALL be unaffected.
REQ-027 Simultaneous enqueue and dequeue when not full SHALL leave count unchanged. Pointers SHALL wrap modulo QDEPTH.

Reset
REQ-028 On reset, the FIFO SHALL be emptied (count = 0, pointers = 0) and all MSHR valid bits cleared.
REQ-029 During and immediately after reset: icache_pf_stall = 0, proc2mem_command = BUS_NONE, proc2mem_addr = 0, pf_wr_en = 0, pf_wr_addr = 0, pf_wr_data = 0.
REQ-030 Reset asserted mid-operation SHALL override all other inputs. Completions arriving after reset for pre-reset tags SHALL be ignored per REQ-024.

Verification
REQ-031 Basic fill: request 0x1000 with hit = 0; response = 3 at the next cycle; tag = 3 after 5 cycles -> BUS_LOAD 0x1000 at cycle 1, then pf_wr_en with addr 0x1000 and the given data; MSHR[3] cleared.
REQ-032 Dedup/hit: request 0x2004 twice, then 0x2000, then 0x3000 with hit = 1 -> exactly one BUS_LOAD, to 0x2000.
REQ-033 Full/stall: demand_mem_busy = 1 and 5 distinct requests -> 4 queued, stall = 1, 5th dropped. Release busy -> 4 issues in FIFO order.
REQ-034 Retry/busy: response = 0 for 2 cycles, then 7 -> the same address is reissued each cycle until accepted; a demand_mem_busy cycle shows BUS_NONE.
REQ-035 Flush: queue 3 requests, and pf_flush in the cycle the head is accepted with tag 9 -> FIFO empty, MSHR[9] valid, later tag = 9 writes the head address.
REQ-036 Foreign completion: tag = 5 with no MSHR[5] -> pf_wr_en = 0. Reset mid-queue -> all outputs at reset values next cycle.
